// File: rtl/fp_mul_arb_pkg.sv
// fp_mul_arb_pkg
// Shared types and helpers for the fp_mul arbiter slice.
//   arb_state_e : drain FSM state encoding
//   rm_t        : fp_mul rounding-mode field
//   RM_*        : rounding-mode encodings driven on mul_rounding_mode
//   id_width()  : requester index width for a given requester count
//   tag_width() : tag pipeline entry width (valid bit + requester id)
package fp_mul_arb_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } arb_state_e;

    typedef logic [2:0] rm_t;

    localparam rm_t RM_RNE = 3'd0;
    localparam rm_t RM_RTZ = 3'd1;
    localparam rm_t RM_RDN = 3'd2;
    localparam rm_t RM_RUP = 3'd3;
    localparam rm_t RM_RMM = 3'd4;

    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int tag_width(input int n_req);
        return id_width(n_req) + 1;
    endfunction

endpackage

// File: rtl/fp_mul_arb_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo N_REQ.
//   req     : request vector
//   ptr     : highest-priority index this cycle (always < N_REQ)
//   enable  : gate for all grants
//   gnt     : one-hot grant (zero when nothing requested or disabled)
//   gnt_idx : index of the granted requester (0 when no grant)
module rr_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    always_comb begin
        int               idx;
        logic             found;
        logic [IDX_W-1:0] sel;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            sel = IDX_W'(idx);
            if (enable && !found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arb.sv
// fp_mul_arb
// Shares one fixed-latency fp_mul among N_REQ requesters. Requests are picked
// round-robin, operands are registered onto mul_*, and a tag pipeline of depth
// MUL_LATENCY+1 steers each result back to its issuer as a one-hot strobe.
// A drain FSM stops issuing and reports when the multiplier pipe is empty.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_rm  : packed per-requester operands and rounding mode
//   mul_a/mul_b/mul_rounding_mode : registered operands to fp_mul
//   mul_result          : fp_mul result, MUL_LATENCY cycles after mul_*
//   rsp_valid/rsp_result: one-hot result strobe and shared result bus
//   drain_req/drain_done: drain request level and drained indication
//   busy                : any operation in flight in the multiplier
// Optional build macro FP_MUL_ARB_PERF_EN adds perf_issue_cnt and
// perf_conflict_cnt (saturating 32-bit event counters).
//
// state   | meaning
// RUN     | arbitrating and issuing
// DRAIN   | issue stopped, waiting for in-flight ops to retire
// DRAINED | pipeline empty, drain_done high until drain_req drops
module fp_mul_arb
    import fp_mul_arb_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int N_REQ       = 4,
    parameter int MUL_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*3-1:0]     req_rm,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    output logic [2:0]             mul_rounding_mode,
    input  logic [WIDTH-1:0]       mul_result,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_result,
    input  logic                   drain_req,
    output logic                   drain_done,
    output logic                   busy
`ifdef FP_MUL_ARB_PERF_EN
    ,
    output logic [31:0]            perf_issue_cnt,
    output logic [31:0]            perf_conflict_cnt
`endif
);

    localparam int IDX_W = id_width(N_REQ);
    localparam int TAG_W = tag_width(N_REQ);
    localparam int DEPTH = MUL_LATENCY + 1;

    localparam logic [1:0] ST_RUN     = RUN;
    localparam logic [1:0] ST_DRAIN   = DRAIN;
    localparam logic [1:0] ST_DRAINED = DRAINED;

    logic [1:0]       state, state_nxt;
    logic [IDX_W-1:0] ptr, gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             arb_en, issue;
    logic [TAG_W-1:0] tag_pipe [DEPTH];
    logic [TAG_W-1:0] tag_out;
    rm_t              sel_rm;

    // Grants are suppressed in the very cycle drain_req rises, and while reset
    // is held so that req_ready reads zero during reset.
    assign arb_en = (state == ST_RUN) && !drain_req && !rst;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .enable  (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign issue     = |gnt;
    assign sel_rm    = req_rm[gnt_idx*3 +: 3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr               <= '0;
            mul_a             <= '0;
            mul_b             <= '0;
            mul_rounding_mode <= '0;
        end else if (issue) begin
            ptr               <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            mul_a             <= req_a[gnt_idx*WIDTH +: WIDTH];
            mul_b             <= req_b[gnt_idx*WIDTH +: WIDTH];
            mul_rounding_mode <= sel_rm;
        end
    end

    // Stage d holds the tag of the op whose operands were registered d edges
    // ago; the last stage lines up with mul_result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                tag_pipe[d] <= '0;
            end
        end else begin
            tag_pipe[0] <= {issue, gnt_idx};
            for (int d = 1; d < DEPTH; d++) begin
                tag_pipe[d] <= tag_pipe[d-1];
            end
        end
    end

    assign tag_out = tag_pipe[DEPTH-1];

    always_comb begin
        busy = 1'b0;
        for (int d = 0; d < DEPTH; d++) begin
            busy = busy | tag_pipe[d][TAG_W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
        end else begin
            rsp_valid <= tag_out[TAG_W-1] ? (N_REQ'(1) << tag_out[IDX_W-1:0]) : '0;
            if (tag_out[TAG_W-1]) begin
                rsp_result <= mul_result;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:     if (drain_req) state_nxt = ST_DRAIN;
            ST_DRAIN:   if (!drain_req) state_nxt = ST_RUN;
                        else if (!busy) state_nxt = ST_DRAINED;
            ST_DRAINED: if (!drain_req) state_nxt = ST_RUN;
            default:    state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign drain_done = (state == ST_DRAINED);

`ifdef FP_MUL_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (issue && (perf_issue_cnt != '1)) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if ((state == ST_RUN) && ($countones(req_valid) > 1) && (perf_conflict_cnt != '1)) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
